sha256_computation: RTL and testbench
=====================================

SHA256_COMPUTATION -- requirements
Module: sha256_computation

Interface
REQ-001 Parameters: none; all widths fixed by SHA-256.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; initialises the block for a new 512-bit block compression.
REQ-005 w_in  input  32  message-schedule word W[t] for the current round; sampled every round cycle.
REQ-006 k_in  input  32  round constant K[t] for the current round; sampled together with w_in.
REQ-007 h_in  input  256  chaining value H0..H7, with H0 in bits [255:224] and H7 in bits [31:0]; sampled only while reset is high.
REQ-008 h_out  output  256  updated chaining value in the same word order as h_in; valid while done=1.
REQ-009 done  output  1  high once h_out is valid; stays high until the next reset.

Function
REQ-010 Internal registers SHALL be: working variables a,b,c,d,e,f,g,h (32 b each), a latched copy hreg of h_in (256 b), and a 7-bit round counter round. Names a, e and round are visible to the bench hierarchically.
REQ-011 The state machine SHALL have three states: ROUND (round 0..63), FINAL (round==64), DONE. Leaving reset enters ROUND with round=0.
REQ-012 In ROUND, each rising edge SHALL perform one compression round:
- T1 = h + S1(e) + Ch(e,f,g) + k_in + w_in
- T2 = S0(a) + Maj(a,b,c)
- h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
- round increments by 1
REQ-013 Round functions:
- S1 = ROTR6^ROTR11^ROTR25(e)
- S0 = ROTR2^ROTR13^ROTR22(a)
- Ch = (e&f)^(~e&g)
- Maj = (a&b)^(a&c)^(b&c)
REQ-014 All additions SHALL be modulo 2^32.
REQ-015 The edge on which round goes 63->64 SHALL move the FSM to FINAL.
REQ-016 In FINAL, the next edge SHALL register h_out = {H0+a, H1+b, ..., H7+h}, taken word-wise mod 2^32 using hreg, set done=1, and move to DONE.
REQ-017 Latency: round t consumes the w_in/k_in presented before the (t+1)th edge after reset deassertion; done rises on the 65th edge after reset deassertion.
REQ-018 In DONE, all state SHALL hold; w_in, k_in and h_in SHALL be ignored, and h_out and done SHALL remain stable.
REQ-019 Changes to h_in after reset deassertion SHALL NOT affect the result.
REQ-020 The block SHALL have no stall input; one round per clock is mandatory.

Reset
REQ-021 While reset=1 at a rising edge, the block SHALL load a..h <= H0..H7 of h_in and hreg <= h_in, and set round=0, state=ROUND, done=0, h_out=0.
REQ-022 Reset asserted mid-operation, in any state, SHALL abort the current computation and reinitialise per REQ-021 on that edge.
REQ-023 The first round SHALL occur on the first edge with reset=0.

Structure
REQ-024 A shared package SHALL hold:
- constants ROUNDS=64 and WORD=32
- the SHA-256 initial value IV
- the 64-entry K table (used by the bench and by the future schedule block)
- the functions rotr, S0, S1, Ch, Maj
REQ-025 One sub-module is natural: sha256_round, a purely combinational single round mapping a..h, w, k to the next a..h. The top holds the FSM, registers and final add. The W schedule and the K ROM are outside this block.

Verification
REQ-026 Reset with h_in=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), w_in=0, k_in=428a2f98, one edge -> a=fc08884d, e=98c7e2a2, round=1.
REQ-027 Reset with h_in=IV, then feed the correct "abc" schedule (W0=61626380, W1..W14=0, W15=00000018, rest expanded) with the true K table -> done on the 65th edge and h_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-028 After done, keep toggling w_in, k_in and h_in for 10 cycles -> h_out and done unchanged.
REQ-029 Assert reset at round 30, then restart the "abc" run -> done=0 and h_out=0 during reset; the same digest as REQ-027 after 65 edges.
REQ-030 Change h_in to zeros after reset deassertion during the "abc" run -> digest still matches REQ-027; done is low before edge 65 and high from edge 65 on.

Source files
------------

// File: rtl/sha256_computation_pkg.sv
// Shared SHA-256 constants, the working-variable bundle and the round functions.
// Used by the compression datapath, the testbench and the future schedule block.
package sha256_computation_pkg;

    localparam int ROUNDS = 64;
    localparam int WORD   = 32;

    typedef logic [WORD-1:0] word_t;

    // Field order matches h_in: a/H0 in the most significant word.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (WORD - n));
    endfunction

    function automatic word_t S0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t S1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t Ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t Maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_computation_round.sv
// One combinational SHA-256 compression round: a..h, W[t], K[t] -> next a..h.
// Zero latency, no flow control; the caller registers the result.
module sha256_round
    import sha256_computation_pkg::*;
(
    input  work_t       st_in,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output work_t       st_out
);

    word_t t1;
    word_t t2;

    always_comb begin
        t1 = st_in.h + S1(st_in.e) + Ch(st_in.e, st_in.f, st_in.g) + k + w;
        t2 = S0(st_in.a) + Maj(st_in.a, st_in.b, st_in.c);

        st_out.a = t1 + t2;
        st_out.b = st_in.a;
        st_out.c = st_in.b;
        st_out.d = st_in.c;
        st_out.e = st_in.d + t1;
        st_out.f = st_in.e;
        st_out.g = st_in.f;
        st_out.h = st_in.g;
    end

endmodule

// File: rtl/sha256_computation.sv
// SHA-256 single-block compression: 64 rounds, one final add, done 65 edges after reset drops.
// No stall: w_in/k_in must be presented every cycle; results hold until the next reset.
module sha256_computation
    import sha256_computation_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  w_in,
    input  logic [31:0]  k_in,
    input  logic [255:0] h_in,
    output logic [255:0] h_out,
    output logic         done
);

    localparam logic [1:0] ST_ROUND = 2'd0;
    localparam logic [1:0] ST_FINAL = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    work_t        st_q,    st_d,    st_next;
    logic [255:0] hreg_q,  hreg_d;
    logic [6:0]   round_q, round_d;
    logic [1:0]   state_q, state_d;
    logic [255:0] h_out_q, h_out_d;
    logic         done_q,  done_d;

    // Aliases kept under their architectural names for hierarchical access.
    word_t      a;
    word_t      e;
    logic [6:0] round;
    assign a     = st_q.a;
    assign e     = st_q.e;
    assign round = round_q;

    sha256_round u_round (
        .st_in  (st_q),
        .w      (w_in),
        .k      (k_in),
        .st_out (st_next)
    );

    always_comb begin
        st_d    = st_q;
        hreg_d  = hreg_q;
        round_d = round_q;
        state_d = state_q;
        h_out_d = h_out_q;
        done_d  = done_q;
        case (state_q)
            ST_ROUND: begin
                st_d    = st_next;
                round_d = round + 7'd1;
                if (round == 7'(ROUNDS - 1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                h_out_d = {hreg_q[255:224] + a,      hreg_q[223:192] + st_q.b,
                           hreg_q[191:160] + st_q.c, hreg_q[159:128] + st_q.d,
                           hreg_q[127:96]  + e,      hreg_q[95:64]   + st_q.f,
                           hreg_q[63:32]   + st_q.g, hreg_q[31:0]    + st_q.h};
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= work_t'(h_in);
            hreg_q  <= h_in;
            round_q <= 7'd0;
            state_q <= ST_ROUND;
            h_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            hreg_q  <= hreg_d;
            round_q <= round_d;
            state_q <= state_d;
            h_out_q <= h_out_d;
            done_q  <= done_d;
        end
    end

    assign h_out = h_out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sha256_computation.sv
// Directed bench for sha256_computation: single-round check, "abc" digest runs,
// hold-after-done, mid-run abort and h_in change after reset, with a digest scoreboard.
module tb_sha256_computation;
    import sha256_computation_pkg::*;

    localparam logic [255:0] DIGEST_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [31:0]  w_in = '0;
    logic [31:0]  k_in = '0;
    logic [255:0] h_in = '0;
    logic [255:0] h_out;
    logic         done;

    int n_checks = 0;
    int n_err    = 0;

    logic [255:0] exp_q[$];
    logic [31:0]  w_sched[64];
    logic [0:63][31:0] k_tab;

    sha256_computation dut (
        .clk   (clk),
        .reset (reset),
        .w_in  (w_in),
        .k_in  (k_in),
        .h_in  (h_in),
        .h_out (h_out),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reset edge happens with reset still high at the sampling point, then reset drops.
    task automatic do_reset(input logic [255:0] h);
        @(negedge clk);
        reset = 1'b1;
        h_in  = h;
        @(negedge clk);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_hout", h_out, 256'd0);
        chk("rst_round", {249'd0, dut.round}, 256'd0);
        reset = 1'b0;
    endtask

    task automatic run_abc(input bit zero_h, input string tag);
        int edges;
        logic [255:0] exp_d;
        exp_q.push_back(DIGEST_ABC);
        edges = 0;
        for (int t = 0; t < 64; t++) begin
            w_in = w_sched[t];
            k_in = k_tab[t];
            @(negedge clk);
            edges++;
            if (zero_h && t == 0) h_in = '0;
            if (t == 31) chk({tag, "_mid_done"}, {255'd0, done}, 256'd0);
        end
        chk({tag, "_done_e64"}, {255'd0, done}, 256'd0);
        chk({tag, "_round64"}, {249'd0, dut.round}, 256'd64);
        w_in = $urandom;
        k_in = $urandom;
        while (done !== 1'b1 && edges < 80) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, "_done_edge"}, 256'(edges), 256'd65);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 256'd1, 256'd0);
        end else begin
            exp_d = exp_q.pop_front();
            chk({tag, "_digest"}, h_out, exp_d);
        end
    endtask

    initial begin
        k_tab = K;
        for (int t = 0; t < 16; t++) w_sched[t] = '0;
        w_sched[0]  = 32'h61626380;
        w_sched[15] = 32'h00000018;
        for (int t = 16; t < 64; t++)
            w_sched[t] = ss1(w_sched[t-2]) + w_sched[t-7] + ss0(w_sched[t-15]) + w_sched[t-16];

        // Single round from IV with W=0.
        do_reset(IV);
        w_in = 32'h0;
        k_in = 32'h428a2f98;
        @(negedge clk);
        chk("r1_a", {224'd0, dut.a}, {224'd0, 32'hfc08884d});
        chk("r1_e", {224'd0, dut.e}, {224'd0, 32'h98c7e2a2});
        chk("r1_round", {249'd0, dut.round}, 256'd1);

        // Full "abc" block.
        do_reset(IV);
        run_abc(1'b0, "abc");

        // Inputs toggling after done must not disturb results.
        for (int i = 0; i < 10; i++) begin
            w_in = $urandom;
            k_in = $urandom;
            h_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("hold_hout", h_out, DIGEST_ABC);
            chk("hold_done", {255'd0, done}, 256'd1);
        end

        // Abort at round 30, then restart.
        do_reset(IV);
        for (int t = 0; t < 30; t++) begin
            w_in = w_sched[t];
            k_in = k_tab[t];
            @(negedge clk);
        end
        chk("abort_round30", {249'd0, dut.round}, 256'd30);
        do_reset(IV);
        run_abc(1'b0, "restart");

        // h_in cleared after reset drops must not matter.
        do_reset(IV);
        run_abc(1'b1, "hchg");

        chk("sb_drained", 256'(exp_q.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
